pixel_fetch_server: RTL
=======================

// Module: pixel_fetch_server
// PURPOSE
//  Responder side of the pixel-fetch interface driven by the display data path. It accepts
//  one request at a time (address + image select) and reads the addressed image memory,
//  which has fixed synchronous read latency. It returns one 24-bit RGB pixel per request.
//  A one-entry last-pixel cache and a range check skip memory reads when possible.
//  Sits between the display data path and the NUM_IMG image ROM/RAM banks.
// PARAMETERS
//  NUM_IMG        5          number of image banks; valid sel_im_req is 0..NUM_IMG-1
//  MEM_LAT        2          bank read latency in cycles, legal range 1..4
//  IMG_W          160        image width in pixels
//  IMG_H          120        image height; valid addr_req is 0..IMG_W*IMG_H-1 (0..19199)
//  BORDER_COLOUR  24'h000000 pixel returned for an out-of-range address or select
//  CACHE_EN       1          1 enables the last-pixel cache; 0 never hits
// PORTS
//  clock        in   1           single clock, rising edge
//  reset        in   1           synchronous, active-high
//  req_valid    in   1           request present
//  req_ready    out  1           server can accept a request
//  addr_req     in   17          pixel address
//  sel_im_req   in   3           image bank select
//  cache_flush  in   1           invalidate cache (assert after any bank is rewritten)
//  rsp_valid    out  1           one-cycle pulse: pixel_out is new this cycle
//  rsp_hit      out  1           qualifies rsp_valid: 1 = served from cache or range check
//  pixel_out    out  24          returned pixel; holds its value until the next response
//  mem_addr     out  17          shared read address to all banks
//  mem_rd_en    out  NUM_IMG     one-hot bank read enable
//  mem_rdata    in   NUM_IMG*24  bank read data; bank i occupies [24*i+23:24*i]
// BEHAVIOUR
//  Reset values: req_ready=0 while reset=1, rsp_valid=0, rsp_hit=0, pixel_out=0,
//   mem_rd_en=0, mem_addr=0, cache invalid, FSM=IDLE. req_ready=1 on the first cycle after reset.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE.
//  Accept: req_valid&&req_ready sampled at a rising edge (call that edge cycle 0).
//   addr_req and sel_im_req are registered on acceptance. Inputs are ignored outside IDLE.
//  Short path: taken when addr_req>=IMG_W*IMG_H, when sel_im_req>=NUM_IMG, or on a cache hit.
//   Cache hit = valid && addr and sel equal the stored pair && CACHE_EN.
//   Short path result: FSM goes straight to RESP; rsp_valid=1 and rsp_hit=1 in cycle 1.
//   No memory read occurs. Out-of-range requests return BORDER_COLOUR.
//  Miss path: in cycle 1 (ISSUE), mem_addr=request addr and mem_rd_en=1<<sel for one cycle.
//   A down-counter then runs MEM_LAT cycles in WAIT.
//   Bank data is captured in cycle 1+MEM_LAT; rsp_valid=1 and rsp_hit=0 in cycle 2+MEM_LAT.
//   The cache is loaded with {addr, sel, pixel} in the same cycle.
//  mem_addr holds its last value when idle. mem_rd_en is never asserted outside ISSUE.
//  No response back-pressure: the consumer must take pixel_out on the rsp_valid cycle.
//  Next acceptance is possible at the earliest in the cycle after RESP.
//  cache_flush: clears the valid bit at the next edge.
//   Flush in the same edge as acceptance: flush wins, the request takes the miss path
//   (range-check short path still applies).
//   Flush while in ISSUE or WAIT: the in-flight response is delivered but NOT cached.
//  Reset mid-operation: in-flight request dropped, no rsp_valid, mem_rd_en=0 next cycle.
//  Out-of-range requests never modify the cache.
// TESTING (MEM_LAT=2, NUM_IMG=5, bank data = {8'(sel), addr[15:0]})
//  1 Reset, req addr=100 sel=0 -> mem_rd_en=5'b00001 and mem_addr=100 in cycle 1;
//    rsp_valid=1, rsp_hit=0, pixel_out=24'h000064 in cycle 4.
//  2 Repeat addr=100 sel=0 -> rsp_valid=1, rsp_hit=1 in cycle 1; mem_rd_en stays 0.
//  3 Req addr=19200 sel=1, then sel=6 addr=5 -> each gives rsp_valid in cycle 1 with
//    pixel_out=BORDER_COLOUR and no bank read.
//  4 cache_flush on the same edge as a repeat of test 2 -> miss path, rsp_valid in cycle 4.
//  5 reset pulsed in cycle 2 of a miss -> rsp_valid never rises, mem_rd_en=0,
//    req_ready=1 the cycle after reset drops, pixel_out=0.
//  6 Back-to-back miss requests addr=0..3 sel=4 with req_valid held high -> acceptances 5 cycles
//    apart, mem_rd_en=5'b10000 each time, pixel_out=24'h040000..24'h040003 in order.

Source files
------------

// File: rtl/pixel_fetch_server.sv
// pixel_fetch_server: serves one 24-bit RGB pixel per request from NUM_IMG
// image banks with fixed read latency, a last-pixel cache and a range check.
// Ports: clock/reset; req_valid/req_ready/addr_req/sel_im_req request side;
// cache_flush; rsp_valid/rsp_hit/pixel_out response; mem_* shared bank port.
module pixel_fetch_server #(
  parameter int          NUM_IMG       = 5,
  parameter int          MEM_LAT       = 2,
  parameter int          IMG_W         = 160,
  parameter int          IMG_H         = 120,
  parameter logic [23:0] BORDER_COLOUR = 24'h000000,
  parameter bit          CACHE_EN      = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [16:0]           addr_req,
  input  logic [2:0]            sel_im_req,
  input  logic                  cache_flush,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [23:0]           pixel_out,
  output logic [16:0]           mem_addr,
  output logic [NUM_IMG-1:0]    mem_rd_en,
  input  logic [NUM_IMG*24-1:0] mem_rdata
);

  localparam logic [16:0] NPIX = 17'(IMG_W * IMG_H);
  localparam logic [3:0]  NSEL = 4'(NUM_IMG);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [16:0] addr_q;
  logic [2:0]  sel_q;
  logic [2:0]  cnt_q;
  logic        hit_q;
  logic        fill_ok_q;

  logic        c_valid_q;
  logic [16:0] c_addr_q;
  logic [2:0]  c_sel_q;
  logic [23:0] c_pix_q;

  logic        accept;
  logic        oor;
  logic        hit;
  logic        short_path;
  logic        capture;
  logic [23:0] rd_pix;

  assign accept = (state_q == IDLE) && req_valid;

  assign oor = (addr_req >= NPIX) ||
               ({1'b0, sel_im_req} >= NSEL);

  // A flush on the accepting edge takes priority over a hit.
  assign hit = CACHE_EN && c_valid_q && !cache_flush &&
               (c_addr_q == addr_req) &&
               (c_sel_q == sel_im_req);

  assign short_path = oor || hit;
  assign capture    = (state_q == WAIT) && (cnt_q == 3'd0);

  always_comb begin
    rd_pix = '0;
    for (int i = 0; i < NUM_IMG; i++) begin
      if (sel_q == 3'(i)) rd_pix = mem_rdata[24*i +: 24];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    mem_rd_en = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_d = short_path ? RESP : ISSUE;
      end
      ISSUE: begin
        for (int i = 0; i < NUM_IMG; i++) begin
          mem_rd_en[i] = (sel_q == 3'(i));
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      fill_ok_q <= 1'b0;
      pixel_out <= '0;
      mem_addr  <= '0;
      c_valid_q <= 1'b0;
      c_addr_q  <= '0;
      c_sel_q   <= '0;
      c_pix_q   <= '0;
    end else begin
      if (cache_flush) c_valid_q <= 1'b0;

      // A flush during the read means the returning pixel may be stale.
      if (cache_flush &&
          (state_q == ISSUE || state_q == WAIT))
        fill_ok_q <= 1'b0;

      if (accept) begin
        addr_q    <= addr_req;
        sel_q     <= sel_im_req;
        hit_q     <= short_path;
        fill_ok_q <= 1'b1;
        if (oor)      pixel_out <= BORDER_COLOUR;
        else if (hit) pixel_out <= c_pix_q;
        else          mem_addr  <= addr_req;
      end

      if (state_q == ISSUE) cnt_q <= 3'(MEM_LAT - 1);
      if (state_q == WAIT && cnt_q != 3'd0)
        cnt_q <= cnt_q - 3'd1;

      if (capture) begin
        pixel_out <= rd_pix;
        if (fill_ok_q && !cache_flush) begin
          c_valid_q <= 1'b1;
          c_addr_q  <= addr_q;
          c_sel_q   <= sel_q;
          c_pix_q   <= rd_pix;
        end
      end
    end
  end

endmodule
